mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 173 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential MULTU (shift-add) / DIVU (restoring) unit with HI/LO result registers
// Optional feature macro: MDU_DIV_EN compiles in the divider datapath; without it DIVU completes with fault=1.
module mult_div_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             iRST_N,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             fault
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    // Multiplicand for MULTU, divisor for DIVU.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    // Upper accumulator half (MULTU) or partial remainder (DIVU); one spare bit for carry/borrow.
    logic [WIDTH:0]   hi_acc_q, hi_acc_d;
    // Multiplier shifting out (MULTU) or dividend shifting out / quotient shifting in (DIVU).
    logic [WIDTH-1:0] lo_acc_q, lo_acc_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;

    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH:0]   iter_hi;
    logic [WIDTH-1:0] iter_lo;

    // One shift-add step: add multiplicand to the upper half when the multiplier LSB is set, then shift right with carry.
    always_comb begin
        mul_addend = lo_acc_q[0] ? opnd_q : '0;
        mul_sum    = hi_acc_q + {1'b0, mul_addend};
        mul_hi     = {1'b0, mul_sum[WIDTH:1]};
        mul_lo     = {mul_sum[0], lo_acc_q[WIDTH-1:1]};
    end

`ifdef MDU_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH:0]   div_hi;
    logic [WIDTH-1:0] div_lo;

    // One restoring-division step: shift remainder:dividend left, trial-subtract, keep or restore.
    always_comb begin
        div_shift = {hi_acc_q[WIDTH-1:0], lo_acc_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        if (div_diff[WIDTH+1]) begin
            div_hi = div_shift;
            div_lo = {lo_acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_hi = div_diff[WIDTH:0];
            div_lo = {lo_acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Pick the iteration result for the latched operation.
    always_comb begin
        iter_hi = op_q ? div_hi : mul_hi;
        iter_lo = op_q ? div_lo : mul_lo;
    end
`else
    // Only the multiplier exists; a DIVU request just idles through the iterations.
    always_comb begin
        iter_hi = mul_hi;
        iter_lo = mul_lo;
    end
`endif

    // Next-state logic: accept a request in IDLE, iterate WIDTH times in RUN, publish HI/LO on the last step.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        hi_acc_d = hi_acc_q;
        lo_acc_d = lo_acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        fault_d  = fault_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    op_d     = op;
                    opnd_d   = op ? b : a;
                    lo_acc_d = op ? a : b;
                    hi_acc_d = '0;
                end
            end
            ST_RUN: begin
                hi_acc_d = iter_hi;
                lo_acc_d = iter_lo;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    hi_d    = iter_hi[WIDTH-1:0];
                    lo_d    = iter_lo;
`ifdef MDU_DIV_EN
                    // Divide by zero runs the normal datapath (lo=all ones, hi=dividend) but flags it.
                    fault_d = op_q && (opnd_q == '0);
`else
                    if (op_q) begin
                        hi_d    = '0;
                        lo_d    = '0;
                        fault_d = 1'b1;
                    end else begin
                        fault_d = 1'b0;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            opnd_q   <= '0;
            hi_acc_q <= '0;
            lo_acc_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            hi_acc_q <= hi_acc_d;
            lo_acc_q <= lo_acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with directed vectors
module tb_mult_div_unit;

    logic       clk;
    logic       iRST_N;
    logic       start;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       fault;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       fault;
        int         cyc;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_fail;
    int   cyc;

    mult_div_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .iRST_N(iRST_N),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .fault (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse pops the oldest expectation and compares result and timing.
    always @(negedge clk) begin
        if (iRST_N && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_hi"}, int'(hi), int'(e.hi));
                check({e.name, "_lo"}, int'(lo), int'(e.lo));
                check({e.name, "_fault"}, int'(fault), int'(e.fault));
                check({e.name, "_latency"}, cyc, e.cyc);
            end
        end
    end

    // Drive a request for one edge; the caller is positioned just after a rising edge.
    task automatic issue(input logic iop, input logic [7:0] ia, input logic [7:0] ib,
                         input logic push, input logic [7:0] ehi, input logic [7:0] elo,
                         input logic efault, input string name);
        exp_t e;
        start = 1'b1;
        op    = iop;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.hi    = ehi;
            e.lo    = elo;
            e.fault = efault;
            e.cyc   = cyc + 8;
            e.name  = name;
            exp_q.push_back(e);
        end
        check({name, "_busy"}, int'(busy), 1);
    endtask

    task automatic wait_done(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check({name, "_done_timeout"}, 0, 1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        iRST_N = 1'b0;
        start  = 1'b0;
        op     = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        iRST_N = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hi", int'(hi), 0);
        check("rst_lo", int'(lo), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fault", int'(fault), 0);

        // 13 * 11 = 143
        issue(1'b0, 8'd13, 8'd11, 1'b1, 8'h00, 8'h8F, 1'b0, "mul_13x11");
        wait_done("mul_13x11");
        @(posedge clk);
        #1;

        // 255 * 255 = 0xFE01, then back-to-back 0 * 0x7F in the done cycle
        issue(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFE, 8'h01, 1'b0, "mul_ffxff");
        wait_done("mul_ffxff");
        issue(1'b0, 8'h00, 8'h7F, 1'b1, 8'h00, 8'h00, 1'b0, "mul_b2b");
        wait_done("mul_b2b");
        @(posedge clk);
        #1;

        // 200 / 7 = 28 rem 4
`ifdef MDU_DIV_EN
        issue(1'b1, 8'd200, 8'd7, 1'b1, 8'h04, 8'h1C, 1'b0, "div_200_7");
`else
        issue(1'b1, 8'd200, 8'd7, 1'b1, 8'h00, 8'h00, 1'b1, "div_200_7");
`endif
        wait_done("div_200_7");
        @(posedge clk);
        #1;

        // Divide by zero, then a multiply clears the fault
`ifdef MDU_DIV_EN
        issue(1'b1, 8'd5, 8'd0, 1'b1, 8'h05, 8'hFF, 1'b1, "div_by_zero");
`else
        issue(1'b1, 8'd5, 8'd0, 1'b1, 8'h00, 8'h00, 1'b1, "div_by_zero");
`endif
        wait_done("div_by_zero");
        @(posedge clk);
        #1;
        issue(1'b0, 8'd2, 8'd3, 1'b1, 8'h00, 8'h06, 1'b0, "mul_2x3");
        wait_done("mul_2x3");
        @(posedge clk);
        #1;

        // Start pulsed while busy with different operands must be ignored
        issue(1'b0, 8'd3, 8'd4, 1'b1, 8'h00, 8'h0C, 1'b0, "mul_3x4");
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'h11;
        b     = 8'h22;
        check("ignored_start_busy", int'(busy), 1);
        wait_done("mul_3x4");
        repeat (12) @(posedge clk);
        #1;
        check("single_done_queue", exp_q.size(), 0);
        check("idle_after_single", int'(busy), 0);

        // Reset mid-operation: outputs clear at once and no done follows
        issue(1'b0, 8'h0F, 8'h0F, 1'b0, 8'h00, 8'h00, 1'b0, "mul_abort");
        repeat (3) @(posedge clk);
        #1;
        iRST_N = 1'b0;
        #1;
        check("abort_hi", int'(hi), 0);
        check("abort_lo", int'(lo), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_fault", int'(fault), 0);
        repeat (2) @(posedge clk);
        #1;
        iRST_N = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_busy", int'(busy), 0);

        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        check("global_timeout", 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
